anubis_decrypt: RTL and testbench



---
 rtl/anubis_if.sv | 19 +
 rtl/anubis_decrypt.sv | 214 +++++++++++++++++++++
 tb/tb_anubis_decrypt.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/anubis_if.sv
// Command/result bundle for the Anubis decryption core.
interface anubis_if;
  logic [127:0] data_in;
  logic [1:0]   order;
  logic [127:0] data_out;
  logic         key_ready;
  logic         busy;
  logic         done;

  modport master (
    output data_in, order,
    input  data_out, key_ready, busy, done
  );

  modport slave (
    input  data_in, order,
    output data_out, key_ready, busy, done
  );
endinterface

// File: rtl/anubis_decrypt.sv
// Anubis-128 decryption core (AES S-box variant): expands the key once into a round-key
// buffer, then runs one inverse round per clock using the stored keys in reverse order.
module anubis_decrypt #(
  parameter int unsigned ROUNDS = 12
) (
  input logic      clk,
  input logic      reset,
  anubis_if.slave  bus
);
  // Byte 0 is the most significant byte; byte 4*i+j is row i, column j.
  typedef logic [0:15][7:0] blk_t;
  typedef enum logic [2:0] {StIdle, StKeyExp, StKeyed, StLoaded, StDecrypt, StDone} state_e;

  localparam logic [3:0] LastRound = 4'(ROUNDS);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic blk_t gamma_f(input blk_t s);
    blk_t r;
    for (int i = 0; i < 16; i++) r[i] = SBOX[s[i]];
    return r;
  endfunction

  function automatic blk_t gamma_inv_f(input blk_t s);
    blk_t r;
    for (int i = 0; i < 16; i++) r[i] = SBOX_INV[s[i]];
    return r;
  endfunction

  // Matrix transpose; its own inverse.
  function automatic blk_t tau_f(input blk_t s);
    blk_t r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) r[4*i+j] = s[4*j+i];
    return r;
  endfunction

  // Multiply by coefficient {01,02,04,06}[c] in GF(2^8) mod x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] hmul(input logic [7:0] a, input logic [1:0] c);
    logic [7:0] a2, a4;
    a2 = {a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00);
    a4 = {a2[6:0], 1'b0} ^ (a2[7] ? 8'h1d : 8'h00);
    case (c)
      2'd0:    return a;
      2'd1:    return a2;
      2'd2:    return a4;
      default: return a4 ^ a2;
    endcase
  endfunction

  // Each row times had(01,02,04,06); the Hadamard matrix squares to identity.
  function automatic blk_t theta_f(input blk_t s);
    blk_t r;
    logic [7:0] acc;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= hmul(s[4*i+k], 2'(k ^ j));
        r[4*i+j] = acc;
      end
    return r;
  endfunction

  // Key evolution for round r: theta(pi(gamma(k))) with round constant S[4(r-1)+j] on row 0.
  function automatic blk_t key_schedule_f(input blk_t k, input logic [3:0] r);
    blk_t g, p, t;
    g = gamma_f(k);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) p[4*i+j] = g[4*((i - j + 4) % 4) + j];
    t = theta_f(p);
    for (int j = 0; j < 4; j++) t[j] ^= SBOX[8'(4 * (int'(r) - 1) + j)];
    return t;
  endfunction

  // Round-key extraction from the evolving key register.
  function automatic blk_t fi_f(input blk_t k);
    return tau_f(gamma_f(k));
  endfunction

  state_e       state_q, state_d;
  logic [1:0]   order_q;
  logic [127:0] din_q;
  logic [127:0] kreg_q, kreg_d;
  logic [127:0] d_q, d_d;
  logic [3:0]   ctr_q, ctr_d;
  logic [127:0] dout_q, dout_d;
  logic         key_ready_q, key_ready_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [127:0] rk_q [ROUNDS+1];
  logic         rk_we;
  logic [3:0]   rk_waddr;
  logic [127:0] ks_out, rk_src;

  assign ks_out = key_schedule_f(kreg_q, ctr_q);
  assign rk_src = (state_q == StKeyExp) ? ks_out : din_q;

  // Next-state and datapath decode; order and data_in are registered once before use.
  always_comb begin
    state_d     = state_q;
    kreg_d      = kreg_q;
    d_d         = d_q;
    ctr_d       = ctr_q;
    dout_d      = dout_q;
    key_ready_d = key_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rk_we       = 1'b0;
    rk_waddr    = ctr_q;
    unique case (state_q)
      StIdle, StKeyed, StLoaded: begin
        if (order_q == 2'b00) begin
          kreg_d      = din_q;
          rk_we       = 1'b1;
          rk_waddr    = 4'd0;
          ctr_d       = 4'd1;
          key_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = StKeyExp;
        end else if (order_q == 2'b01 && state_q != StIdle) begin
          d_d     = din_q;
          state_d = StLoaded;
        end else if (order_q == 2'b10 && state_q == StLoaded) begin
          d_d     = d_q ^ rk_q[ROUNDS];
          ctr_d   = 4'd1;
          busy_d  = 1'b1;
          state_d = StDecrypt;
        end
      end
      StKeyExp: begin
        kreg_d = ks_out;
        rk_we  = 1'b1;
        ctr_d  = ctr_q + 4'd1;
        if (ctr_q == LastRound) begin
          key_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = StKeyed;
        end
      end
      StDecrypt: begin
        if (ctr_q == LastRound) begin
          dout_d  = tau_f(gamma_inv_f(d_q)) ^ rk_q[0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StDone;
        end else begin
          // theta is linear, so the round key is moved through it instead of the state.
          d_d   = theta_f(tau_f(gamma_inv_f(d_q))) ^ theta_f(rk_q[LastRound - ctr_q]);
          ctr_d = ctr_q + 4'd1;
        end
      end
      StDone:  state_d = StKeyed;
      default: state_d = StIdle;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      order_q     <= 2'b11;
      din_q       <= '0;
      kreg_q      <= '0;
      d_q         <= '0;
      ctr_q       <= '0;
      dout_q      <= '0;
      key_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      order_q     <= bus.order;
      din_q       <= bus.data_in;
      kreg_q      <= kreg_d;
      d_q         <= d_d;
      ctr_q       <= ctr_d;
      dout_q      <= dout_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Round-key buffer; key_ready guards its contents, so it needs no reset.
  always_ff @(posedge clk) begin
    if (rk_we) rk_q[rk_waddr] <= fi_f(rk_src);
  end

  assign bus.data_out  = dout_q;
  assign bus.key_ready = key_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_anubis_decrypt.sv
// Bench for anubis_decrypt: a reference Anubis encryptor produces ciphertexts whose
// decryption must return the original plaintext, plus timing and command-filter checks.
module tb_anubis_decrypt;
  typedef logic [0:15][7:0] blk_t;

  localparam logic [0:255][7:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  anubis_if bus ();

  anubis_decrypt #(.ROUNDS(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference encryption model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1d) : (x << 1);
    end
    return p;
  endfunction

  function automatic blk_t m_gamma(input blk_t s);
    blk_t r;
    for (int i = 0; i < 16; i++) r[i] = SB[s[i]];
    return r;
  endfunction

  function automatic blk_t m_tau(input blk_t s);
    blk_t r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) r[4*j+i] = s[4*i+j];
    return r;
  endfunction

  function automatic blk_t m_theta(input blk_t s);
    blk_t r;
    logic [7:0] h [4];
    h[0] = 8'h01; h[1] = 8'h02; h[2] = 8'h04; h[3] = 8'h06;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[4*i+j] = gmul(s[4*i], h[j]) ^ gmul(s[4*i+1], h[1^j]) ^
                   gmul(s[4*i+2], h[2^j]) ^ gmul(s[4*i+3], h[3^j]);
    return r;
  endfunction

  // Key evolution: column j shifted down by j rows, then theta, round constant on row 0.
  function automatic blk_t m_ks(input blk_t k, input int r);
    blk_t g, p, t;
    g = m_gamma(k);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) p[4*((i + j) % 4) + j] = g[4*i+j];
    t = m_theta(p);
    for (int j = 0; j < 4; j++) t[j] = t[j] ^ SB[8'(4*(r-1)+j)];
    return t;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] rk [13];
    blk_t k, x;
    k = key;
    rk[0] = m_tau(m_gamma(k));
    for (int r = 1; r <= 12; r++) begin
      k = m_ks(k, r);
      rk[r] = m_tau(m_gamma(k));
    end
    x = pt ^ rk[0];
    for (int r = 1; r < 12; r++) x = m_theta(m_tau(m_gamma(x))) ^ rk[r];
    return m_tau(m_gamma(x)) ^ rk[12];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    bit ok;
    bus.order = 2'b00;
    bus.data_in = k;
    step();
    bus.order = 2'b11;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      step();
      if (bus.key_ready === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL key_load_timeout: key_ready=%b want 1", bus.key_ready);
    end
  endtask

  // Loads ciphertext, starts, and returns data_out at done plus the edge count from start.
  task automatic run_decrypt(input logic [127:0] ct, output logic [127:0] out, output int lat);
    bus.order = 2'b01;
    bus.data_in = ct;
    step();
    bus.order = 2'b11;
    step();
    bus.order = 2'b10;
    step();
    bus.order = 2'b11;
    lat = -1;
    out = '0;
    for (int n = 1; n <= 30 && lat < 0; n++) begin
      step();
      if (bus.done === 1'b1) begin
        lat = n;
        out = bus.data_out;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.order = 2'b11;
    bus.data_in = '0;
    repeat (3) step();
    checks += 4;
    if (bus.key_ready !== 1'b0) begin errors++; $display("FAIL rst_key_ready: got %b want 0", bus.key_ready); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.done); end
    if (bus.data_out !== 128'h0) begin errors++; $display("FAIL rst_data_out: got %h want 0", bus.data_out); end
    reset = 1'b0;
    step();
    // 01 then 10 in IDLE: if 01 were accepted, the 10 would start a decryption.
    bus.order = 2'b01;
    bus.data_in = 128'h1234;
    step();
    bus.order = 2'b10;
    step();
    bus.order = 2'b11;
    for (int n = 0; n < 5; n++) begin
      step();
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.key_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_ignore: busy=%b done=%b key_ready=%b want 0 0 0",
                 bus.busy, bus.done, bus.key_ready);
      end
    end
  endtask

  task automatic test_key_expansion();
    logic [127:0] key, pt, out;
    int lat;
    key = 128'h000102030405060708090a0b0c0d0e0f;
    pt  = 128'h00112233445566778899aabbccddeeff;
    bus.order = 2'b00;
    bus.data_in = key;
    step();
    bus.order = 2'b11;
    for (int n = 1; n <= 13; n++) begin
      step();
      checks += 2;
      if (bus.busy !== (n <= 12)) begin
        errors++;
        $display("FAIL kexp_busy edge %0d: got %b want %b", n, bus.busy, (n <= 12));
      end
      if (bus.key_ready !== (n == 13)) begin
        errors++;
        $display("FAIL kexp_key_ready edge %0d: got %b want %b", n, bus.key_ready, (n == 13));
      end
    end
    run_decrypt(encrypt(key, pt), out, lat);
    checks += 2;
    if (lat != 13) begin errors++; $display("FAIL kexp_latency: got %0d want 13", lat); end
    if (out !== pt) begin errors++; $display("FAIL kexp_roundtrip: got %h want %h", out, pt); end
  endtask

  task automatic test_round_trip_zero();
    logic [127:0] out;
    int lat;
    load_key('0);
    run_decrypt(encrypt('0, '0), out, lat);
    checks += 3;
    if (lat != 13) begin errors++; $display("FAIL zero_latency: got %0d want 13", lat); end
    if (out !== 128'h0) begin errors++; $display("FAIL zero_plaintext: got %h want 0", out); end
    step();
    if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b want 0", bus.done); end
  endtask

  task automatic test_random_pairs();
    logic [127:0] key, pt, out;
    int lat;
    for (int t = 0; t < 100; t++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      load_key(key);
      run_decrypt(encrypt(key, pt), out, lat);
      checks++;
      if (out !== pt || lat != 13) begin
        errors++;
        $display("FAIL random_%0d: got %h lat %0d want %h lat 13", t, out, lat, pt);
      end
    end
    // Result must hold until the next one.
    repeat (3) step();
    checks++;
    if (bus.data_out !== pt) begin errors++; $display("FAIL data_out_hold: got %h want %h", bus.data_out, pt); end
  endtask

  task automatic test_filtering();
    logic [127:0] key, pt, out;
    int lat;
    key = 128'hfedcba9876543210_0f1e2d3c4b5a6978;
    pt  = 128'h0123456789abcdef_deadbeefcafef00d;
    load_key(key);
    // Start in KEYED without a ciphertext.
    bus.order = 2'b10;
    step();
    bus.order = 2'b11;
    for (int n = 0; n < 5; n++) begin
      step();
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL keyed_start_ignored: busy=%b done=%b want 0 0", bus.busy, bus.done);
      end
    end
    // Key and ciphertext loads during decryption must be ignored.
    bus.order = 2'b01;
    bus.data_in = encrypt(key, pt);
    step();
    bus.order = 2'b11;
    step();
    bus.order = 2'b10;
    step();
    bus.order = 2'b00;
    bus.data_in = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;
    repeat (3) step();
    bus.order = 2'b01;
    repeat (3) step();
    bus.order = 2'b11;
    lat = 6;
    out = '0;
    for (int n = 7; n <= 30 && lat == 6; n++) begin
      step();
      if (bus.done === 1'b1) begin
        lat = n;
        out = bus.data_out;
      end
    end
    checks += 3;
    if (lat != 13) begin errors++; $display("FAIL busy_cmd_latency: got %0d want 13", lat); end
    if (out !== pt) begin errors++; $display("FAIL busy_cmd_result: got %h want %h", out, pt); end
    if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL busy_cmd_key_kept: got %b want 1", bus.key_ready); end
    // Restart without reloading a ciphertext.
    step();
    bus.order = 2'b10;
    step();
    bus.order = 2'b11;
    for (int n = 0; n < 5; n++) begin
      step();
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL restart_ignored: busy=%b done=%b want 0 0", bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_rekey_loaded();
    logic [127:0] key_a, key_b, pt, ct, out;
    int lat;
    key_a = 128'h11111111222222223333333344444444;
    key_b = 128'h89abcdef0123456789abcdef01234567;
    pt    = 128'h00000000000000010000000000000002;
    ct    = encrypt(key_b, pt);
    load_key(key_a);
    bus.order = 2'b01;
    bus.data_in = ct;
    step();
    bus.order = 2'b11;
    step();
    load_key(key_b);
    bus.order = 2'b10;
    step();
    bus.order = 2'b11;
    for (int n = 0; n < 4; n++) begin
      step();
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL rekey_discard: busy=%b want 0", bus.busy);
      end
    end
    run_decrypt(ct, out, lat);
    checks++;
    if (out !== pt || lat != 13) begin
      errors++;
      $display("FAIL rekey_result: got %h lat %0d want %h lat 13", out, lat, pt);
    end
  endtask

  task automatic test_reset_mid_decrypt();
    logic [127:0] key, pt, ct, out;
    int lat;
    key = 128'h0f0e0d0c0b0a09080706050403020100;
    pt  = 128'hc001d00dc001d00dc001d00dc001d00d;
    ct  = encrypt(key, pt);
    load_key(key);
    bus.order = 2'b01;
    bus.data_in = ct;
    step();
    bus.order = 2'b11;
    step();
    bus.order = 2'b10;
    step();
    bus.order = 2'b11;
    repeat (6) step();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
    reset = 1'b1;
    #1;
    checks += 4;
    if (bus.key_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_key_ready: got %b want 0", bus.key_ready); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %b want 0", bus.done); end
    if (bus.data_out !== 128'h0) begin errors++; $display("FAIL mid_rst_data_out: got %h want 0", bus.data_out); end
    repeat (2) step();
    reset = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      checks++;
      if (bus.done !== 1'b0 || bus.data_out !== 128'h0 || bus.key_ready !== 1'b0) begin
        errors++;
        $display("FAIL post_rst_quiet: done=%b data_out=%h key_ready=%b want 0 0 0",
                 bus.done, bus.data_out, bus.key_ready);
      end
    end
    load_key(key);
    run_decrypt(ct, out, lat);
    checks++;
    if (out !== pt || lat != 13) begin
      errors++;
      $display("FAIL post_rst_result: got %h lat %0d want %h lat 13", out, lat, pt);
    end
  endtask

  initial begin
    test_reset();
    test_key_expansion();
    test_round_trip_zero();
    test_random_pairs();
    test_filtering();
    test_rekey_loaded();
    test_reset_mid_decrypt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
